// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV64 control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BAD
  } op_class_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic op_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:     return CLS_R;
      OP_IMM:   return CLS_IMM;
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      default:  return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bus: instruction fields in, control strobes out.
interface multicycle_controller_if #(parameter int ALU_CC_W = 4);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                mem_ready;
  logic                PCWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic                MemtoReg;
  logic                ALUsrc;
  logic                MemRead;
  logic                MemWrite;
  logic [ALU_CC_W-1:0] ALU_CC;

  modport master (
    input  opcode, funct3, funct7, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemtoReg, ALUsrc, MemRead, MemWrite, ALU_CC
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemtoReg, ALUsrc, MemRead, MemWrite, ALU_CC
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational decode of opcode class + funct fields into an ALU code and legality flag.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_cc,
  output logic        illegal
);

  logic f7_base, f7_alt;
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  always_comb begin
    alu_cc  = ALU_ADD;
    illegal = 1'b0;
    case (op_class)
      CLS_R: begin
        // only add/sub and srl/sra have an alternate funct7
        illegal = !(f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
        case (funct3)
          3'b000:  alu_cc = f7_alt ? ALU_SUB : ALU_ADD;
          3'b001:  alu_cc = ALU_SLL;
          3'b010:  alu_cc = ALU_SLT;
          3'b100:  alu_cc = ALU_XOR;
          3'b101:  alu_cc = f7_alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_cc = ALU_OR;
          3'b111:  alu_cc = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      CLS_IMM: begin
        // funct7 is immediate data except for the shift forms
        case (funct3)
          3'b000:  alu_cc = ALU_ADD;
          3'b001: begin
            alu_cc  = ALU_SLL;
            illegal = !(f7_base || f7_alt);
          end
          3'b010:  alu_cc = ALU_SLT;
          3'b100:  alu_cc = ALU_XOR;
          3'b101: begin
            alu_cc  = f7_alt ? ALU_SRA : ALU_SRL;
            illegal = !(f7_base || f7_alt);
          end
          3'b110:  alu_cc = ALU_OR;
          3'b111:  alu_cc = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      CLS_LOAD, CLS_STORE: illegal = (funct3 != F3_DWORD);
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV64 datapath: fetch/decode/exec/mem/wb sequencing,
// memory-ready stall with timeout trap, illegal-instruction trap and retire counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CC_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus,
  output logic                     instr_done,
  output logic                     trap,
  output logic [1:0]               trap_cause,
  output logic [CNT_W-1:0]         retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_d;
  op_class_t         dec_cls;
  logic [3:0]        dec_cc, alu_cc_q;
  logic              dec_illegal;
  logic              imm_q, store_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              trap_set;
  logic [1:0]        cause_d;
  logic              done;
  logic              pc_write, ir_write, reg_write, mem_to_reg, alu_src, mem_read, mem_write;

  assign dec_cls = classify(bus.opcode);

  alu_decoder u_alu_decoder (
    .op_class (dec_cls),
    .funct3   (bus.funct3),
    .funct7   (bus.funct7),
    .alu_cc   (dec_cc),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_cc_q   <= '0;
      imm_q      <= 1'b0;
      store_q    <= 1'b0;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= TRAP_NONE;
      retired    <= '0;
    end else begin
      state <= state_d;
      if (state == DECODE) begin
        alu_cc_q <= dec_cc;
        imm_q    <= (dec_cls == CLS_IMM);
        store_q  <= (dec_cls == CLS_STORE);
      end
      if (state == MEM_ADDR)
        wait_cnt <= '0;
      else if ((state == MEM_RD || state == MEM_WR) && !bus.mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (trap_set) begin
        trap       <= 1'b1;
        trap_cause <= cause_d;
      end
      if (done)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state;
    trap_set   = 1'b0;
    cause_d    = TRAP_NONE;
    done       = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b1;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        mem_to_reg = 1'b0;
        state_d    = FETCH;
      end
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        if (dec_illegal) begin
          state_d  = TRAP;
          trap_set = 1'b1;
          cause_d  = TRAP_ILLEGAL;
        end else if (dec_cls == CLS_LOAD || dec_cls == CLS_STORE)
          state_d = MEM_ADDR;
        else
          state_d = EXEC;
      end
      EXEC: begin
        alu_src = imm_q;
        state_d = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src = 1'b1;
        state_d = store_q ? MEM_WR : MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        alu_src   = 1'b1;
        mem_read  = (state == MEM_RD);
        mem_write = (state == MEM_WR);
        // completion wins over a timeout reached in the same cycle
        if (bus.mem_ready) begin
          state_d = (state == MEM_RD) ? WB_MEM : FETCH;
          done    = (state == MEM_WR);
        end else if (wait_cnt == WAIT_LAST) begin
          state_d  = TRAP;
          trap_set = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      WB_ALU: begin
        reg_write = 1'b1;
        alu_src   = imm_q;
        done      = 1'b1;
        state_d   = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        done       = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  assign instr_done   = done;
  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUsrc   = alu_src;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.ALU_CC   = ALU_CC_W'(alu_cc_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Random instruction streams against a table-driven reference; scoreboard checks each retire/trap.
module tb_multicycle_controller;

  localparam int MT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_done, trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  multicycle_controller_if #(.ALU_CC_W(4)) ifc ();

  multicycle_controller #(.ALU_CC_W(4), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; int w; } instr_t;
  typedef struct {
    bit is_trap; logic [1:0] cause; int lat; logic [3:0] cc; bit imm; bit ld;
    int mr; int mw; int rw; int ret_after;
  } exp_t;
  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic care; logic [3:0] cc; } enc_t;

  // supported mnemonics; care=0 means funct7 is immediate data
  enc_t tbl [20] = '{
    '{7'h33, 3'd0, 7'h00, 1'b1, 4'd2}, '{7'h33, 3'd0, 7'h20, 1'b1, 4'd6},
    '{7'h33, 3'd1, 7'h00, 1'b1, 4'd4}, '{7'h33, 3'd2, 7'h00, 1'b1, 4'd7},
    '{7'h33, 3'd4, 7'h00, 1'b1, 4'd3}, '{7'h33, 3'd5, 7'h00, 1'b1, 4'd5},
    '{7'h33, 3'd5, 7'h20, 1'b1, 4'd8}, '{7'h33, 3'd6, 7'h00, 1'b1, 4'd1},
    '{7'h33, 3'd7, 7'h00, 1'b1, 4'd0},
    '{7'h13, 3'd0, 7'h00, 1'b0, 4'd2}, '{7'h13, 3'd2, 7'h00, 1'b0, 4'd7},
    '{7'h13, 3'd4, 7'h00, 1'b0, 4'd3}, '{7'h13, 3'd6, 7'h00, 1'b0, 4'd1},
    '{7'h13, 3'd7, 7'h00, 1'b0, 4'd0}, '{7'h13, 3'd1, 7'h00, 1'b1, 4'd4},
    '{7'h13, 3'd1, 7'h20, 1'b1, 4'd4}, '{7'h13, 3'd5, 7'h00, 1'b1, 4'd5},
    '{7'h13, 3'd5, 7'h20, 1'b1, 4'd8},
    '{7'h03, 3'd3, 7'h00, 1'b0, 4'd2}, '{7'h23, 3'd3, 7'h00, 1'b0, 4'd2}
  };

  instr_t iq [$];
  exp_t   eq [$];
  int     n_vec = 0, n_err = 0;
  int     ret_model = 0;
  bit     trap_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input instr_t i, input int ret_before);
    exp_t e = '{default: 0};
    bit legal = 0;
    foreach (tbl[k])
      if (!legal && tbl[k].op == i.op && tbl[k].f3 == i.f3 && (!tbl[k].care || tbl[k].f7 == i.f7)) begin
        legal = 1;
        e.cc  = tbl[k].cc;
      end
    e.imm = (i.op == 7'h13);
    e.ld  = (i.op == 7'h03);
    if (!legal) begin
      e.is_trap = 1; e.cause = 2'b01; e.lat = 3;
    end else if (i.op == 7'h03 || i.op == 7'h23) begin
      if (i.w >= MT) begin
        e.is_trap = 1; e.cause = 2'b10; e.lat = 4 + MT;
        if (e.ld) e.mr = MT; else e.mw = MT;
      end else if (e.ld) begin
        e.lat = 5 + i.w; e.mr = i.w + 1; e.rw = 1;
      end else begin
        e.lat = 4 + i.w; e.mw = i.w + 1;
      end
    end else begin
      e.lat = 4; e.rw = 1;
    end
    e.ret_after = e.is_trap ? ret_before : ret_before + 1;
    return e;
  endfunction

  task automatic push(input instr_t i);
    exp_t e = model(i, ret_model);
    ret_model = e.ret_after;
    iq.push_back(i);
    eq.push_back(e);
  endtask

  function automatic instr_t gen_legal();
    instr_t i;
    enc_t   t = tbl[$urandom_range(0, 19)];
    i.op = t.op; i.f3 = t.f3;
    i.f7 = t.care ? t.f7 : 7'($urandom);
    case ($urandom_range(0, 5))
      0:       i.w = MT - 1;
      default: i.w = $urandom_range(0, 4);
    endcase
    return i;
  endfunction

  function automatic instr_t gen_trap();
    instr_t i;
    do begin
      case ($urandom_range(0, 3))
        0:       i = '{7'($urandom), 3'($urandom), 7'($urandom), 0};
        1:       i = '{($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13, 3'($urandom), 7'($urandom), 0};
        2:       i = '{($urandom_range(0, 1) != 0) ? 7'h03 : 7'h23, 3'($urandom), 7'($urandom), 0};
        default: i = '{($urandom_range(0, 1) != 0) ? 7'h03 : 7'h23, 3'd3, 7'($urandom), MT + $urandom_range(0, 20)};
      endcase
    end while (!model(i, 0).is_trap);
    return i;
  endfunction

  // instruction register / data memory model
  initial begin : driver
    instr_t cur = '{7'h0, 3'h0, 7'h0, 0};
    int     acc = 0;
    ifc.opcode = '0; ifc.funct3 = '0; ifc.funct7 = '0; ifc.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.IRWrite && iq.size() > 0) begin
        cur = iq.pop_front();
        ifc.opcode = cur.op; ifc.funct3 = cur.f3; ifc.funct7 = cur.f7;
      end
      if (!reset && (ifc.MemRead || ifc.MemWrite)) begin
        ifc.mem_ready = (acc >= cur.w);
        acc++;
      end else begin
        acc = 0;
        ifc.mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   active = 0;
    int   cyc = 0, mr = 0, mw = 0, rw = 0, pend = -1, frozen = 0;
    logic [1:0] hold_cause = 2'b00;
    logic [6:0] strobes;
    forever begin
      @(negedge clk); #1;
      strobes = {ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.ALUsrc, ifc.MemRead, ifc.MemWrite, instr_done};
      if (reset) begin
        active = 0; trap_seen = 0; pend = -1;
        continue;
      end
      if (pend >= 0) begin
        chk("retired_inc", retired, pend);
        pend = -1;
      end
      if (trap_seen) begin
        chk("trap_hold", {trap, trap_cause}, {1'b1, hold_cause});
        chk("trap_strobes", strobes, 0);
        chk("trap_retired_frozen", retired, frozen);
        continue;
      end
      if (ifc.IRWrite) begin
        chk("fetch_pcwrite", ifc.PCWrite, 1);
        active = 1; cyc = 1; mr = 0; mw = 0; rw = 0;
      end else if (active) cyc++;
      mr += int'(ifc.MemRead); mw += int'(ifc.MemWrite); rw += int'(ifc.RegWrite);
      if (ifc.MemRead || ifc.MemWrite) chk("mem_alusrc", ifc.ALUsrc, 1);
      if (ifc.RegWrite && eq.size() > 0) begin
        chk("wb_memtoreg", ifc.MemtoReg, !eq[0].ld);
        chk("wb_alusrc", ifc.ALUsrc, eq[0].imm);
      end
      if (instr_done || trap) begin
        if (eq.size() == 0) begin
          chk("unexpected_event", 1, 0);
          hold_cause = trap_cause; frozen = retired;
        end else begin
          e = eq.pop_front();
          chk("is_trap", trap, e.is_trap);
          chk("latency", cyc, e.lat);
          chk("memread_cycles", mr, e.mr);
          chk("memwrite_cycles", mw, e.mw);
          chk("regwrite_cycles", rw, e.rw);
          if (e.is_trap) begin
            chk("trap_cause", trap_cause, e.cause);
            chk("trap_entry_strobes", strobes, 0);
            chk("trap_entry_retired", retired, e.ret_after);
          end else begin
            chk("alu_cc", ifc.ALU_CC, e.cc);
            chk("retired_pre", retired, e.ret_after - 1);
            pend = e.ret_after;
          end
          hold_cause = e.cause; frozen = e.ret_after;
        end
        if (trap) trap_seen = 1;
        active = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_strobes", {ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemtoReg, ifc.ALUsrc,
                        ifc.MemRead, ifc.MemWrite, instr_done}, 0);
    chk("rst_alu_cc", ifc.ALU_CC, 0);
    chk("rst_trap", {trap, trap_cause}, 0);
    chk("rst_retired", retired, 0);
    iq.delete(); eq.delete();
    ret_model = 0;
  endtask

  task automatic run_batch();
    int n = 0;
    @(negedge clk);
    reset = 1'b0;
    while (!(trap_seen && eq.size() == 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) chk("batch_timeout", n, 0);
    repeat (4) @(negedge clk);
    do_reset();
  endtask

  initial begin : stim
    instr_t i;
    int n;
    do_reset();
    // add, sub, srai, ld w/3 stalls, sd, ld finishing on the last allowed cycle, ld timeout
    push('{7'h33, 3'd0, 7'h00, 0});
    push('{7'h33, 3'd0, 7'h20, 0});
    push('{7'h13, 3'd5, 7'h20, 0});
    push('{7'h03, 3'd3, 7'h00, 3});
    push('{7'h23, 3'd3, 7'h00, 0});
    push('{7'h03, 3'd3, 7'h00, MT - 1});
    push('{7'h03, 3'd3, 7'h00, 1000});
    run_batch();
    push('{7'h7f, 3'd0, 7'h00, 0});
    run_batch();
    push('{7'h03, 3'd2, 7'h00, 0});
    run_batch();
    push('{7'h23, 3'd3, 7'h00, 1000});
    run_batch();
    // reset in the middle of a memory wait
    push('{7'h03, 3'd3, 7'h00, 1000});
    @(negedge clk); reset = 1'b0;
    n = 0;
    while (!ifc.MemRead && n < 50) begin @(negedge clk); n++; end
    chk("memread_reached", ifc.MemRead, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_drops_memread", ifc.MemRead, 0);
    do_reset();
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) push(gen_legal());
      i = gen_trap();
      push(i);
      run_batch();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
